booth_mul_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `booth` multiplier among `NREQ` requesters. Accepts operand pairs via per-requester valid/ready, drives the multiplier's operand and `input_bit` start pulse, waits for `done`, and returns `PRODUCT`, `addcnt` and `subcnt` tagged with the requester index on one shared response channel. Sits between client datapaths and the single `booth` instance.

---
 rtl/booth_mul_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_booth_mul_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter
// Round-robin arbiter/sequencer sharing one booth multiplier among NREQ
// requesters. One operation is in flight at a time; the result comes back on
// a single response channel tagged with the owning requester index.
// Optional feature: define BOOTH_ARB_BYPASS_EN to answer requests whose
// multiplier is 0 or -1 directly, without starting the booth multiplier.
//
// state | meaning
// IDLE  | waiting for a request while booth reports done; round-robin grant
// ISSUE | m_start pulse, operands presented from the latch
// ARM   | booth may still show a stale done from the previous job; ignored
// WAIT  | first cycle with m_done captures product and counts
// RESP  | response held on rsp_* until rsp_ready
module booth_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*W-1:0]        req_a,
  input  logic [NREQ*W-1:0]        req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [2*W-1:0]           rsp_product,
  output logic [4:0]               rsp_addcnt,
  output logic [4:0]               rsp_subcnt,
  output logic [W-1:0]             m_multiplicand,
  output logic [W-1:0]             m_multiplier,
  output logic                     m_start,
  input  logic                     m_done,
  input  logic [2*W-1:0]           m_product,
  input  logic [4:0]               m_addcnt,
  input  logic [4:0]               m_subcnt
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_ARM   = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q;
  logic [W-1:0]     a_q, b_q;
  logic             m_start_q, m_start_d;
  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [2*W-1:0]   rsp_product_q;
  logic [4:0]       rsp_addcnt_q, rsp_subcnt_q;

  logic             grant_vld;
  logic [IDW-1:0]   grant_idx;
  int               rr_j;
  logic             accept;
  logic             capture;
  logic             bypass;
  logic [W-1:0]     sel_a, sel_b;

  // Round-robin search: first valid requester at or after ptr, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_j      = 0;
    for (int k = 0; k < NREQ; k++) begin
      rr_j = (int'(ptr_q) + k) % NREQ;
      if (!grant_vld && req_valid[rr_j]) begin
        grant_vld = 1'b1;
        grant_idx = rr_j[IDW-1:0];
      end
    end
  end

  assign sel_a   = req_a[grant_idx*W +: W];
  assign sel_b   = req_b[grant_idx*W +: W];
  // The m_done gate keeps us from granting while booth is still finishing a
  // job that a reset of this block orphaned.
  assign accept  = (state_q == S_IDLE) && m_done && grant_vld;
  assign capture = (state_q == S_WAIT) && m_done;
  assign ptr_d   = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

`ifdef BOOTH_ARB_BYPASS_EN
  logic           byp_neg;
  logic [2*W-1:0] sel_sext;
  assign byp_neg  = (sel_b == '1);
  assign bypass   = (sel_b == '0) || byp_neg;
  assign sel_sext = {{W{sel_a[W-1]}}, sel_a};
`else
  assign bypass   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = bypass ? S_RESP : S_ISSUE;
      S_ISSUE: state_d = S_ARM;
      S_ARM:   state_d = S_WAIT;
      S_WAIT:  if (m_done) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: one-hot ready on the granted requester, start request.
  always_comb begin
    req_ready = '0;
    m_start_d = 1'b0;
    if (accept) begin
      req_ready[grant_idx] = 1'b1;
      m_start_d            = !bypass;
    end
  end

  // Operand latch, pointer, start pulse and response registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q         <= '0;
      id_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      m_start_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_product_q <= '0;
      rsp_addcnt_q  <= '0;
      rsp_subcnt_q  <= '0;
    end else begin
      m_start_q   <= m_start_d;
      rsp_valid_q <= (state_d == S_RESP);
      if (accept) begin
        ptr_q <= ptr_d;
        id_q  <= grant_idx;
        // Bypassed jobs never reach booth, so its operands keep their value.
        if (!bypass) begin
          a_q <= sel_a;
          b_q <= sel_b;
        end
      end
      if (capture) begin
        rsp_id_q      <= id_q;
        rsp_product_q <= m_product;
        rsp_addcnt_q  <= m_addcnt;
        rsp_subcnt_q  <= m_subcnt;
      end
`ifdef BOOTH_ARB_BYPASS_EN
      if (accept && bypass) begin
        rsp_id_q      <= grant_idx;
        rsp_product_q <= byp_neg ? ('0 - sel_sext) : '0;
        rsp_addcnt_q  <= 5'd0;
        rsp_subcnt_q  <= byp_neg ? 5'd1 : 5'd0;
      end
`endif
    end
  end

  assign m_multiplicand = a_q;
  assign m_multiplier   = b_q;
  assign m_start        = m_start_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_id         = rsp_id_q;
  assign rsp_product    = rsp_product_q;
  assign rsp_addcnt     = rsp_addcnt_q;
  assign rsp_subcnt     = rsp_subcnt_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Testbench for booth_mul_arbiter: behavioural booth model, per-requester
// stimulus queues, scoreboard of expected responses and a negedge monitor.
`timescale 1ns/1ps
module tb_booth_mul_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int IDW  = $clog2(NREQ);
  localparam int CAP  = 64;

  logic                clk = 1'b0;
  logic                rstn;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*W-1:0]   req_a, req_b;
  logic                rsp_valid, rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [2*W-1:0]      rsp_product;
  logic [4:0]          rsp_addcnt, rsp_subcnt;
  logic [W-1:0]        m_multiplicand, m_multiplier;
  logic                m_start;
  logic                m_done;
  logic [2*W-1:0]      m_product;
  logic [4:0]          m_addcnt, m_subcnt;

  always #5 clk = ~clk;

  booth_mul_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_product(rsp_product),
    .rsp_addcnt(rsp_addcnt), .rsp_subcnt(rsp_subcnt),
    .m_multiplicand(m_multiplicand), .m_multiplier(m_multiplier),
    .m_start(m_start), .m_done(m_done), .m_product(m_product),
    .m_addcnt(m_addcnt), .m_subcnt(m_subcnt)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
  endtask

  // Booth recoding of the multiplier with an implicit 0 below bit 0:
  // a 0->1 step (reading upwards) is a subtract, a 1->0 step is an add.
  function automatic void booth_counts(input logic [31:0] b, output int ad, output int sb);
    logic prev;
    ad = 0; sb = 0; prev = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (b[i] && !prev) sb++;
      else if (!b[i] && prev) ad++;
      prev = b[i];
    end
  endfunction

  always @(posedge clk) cyc++;

  // ---------------- behavioural booth multiplier ----------------
  int           lat_fixed  = 0;
  int           stale_knob = 0;
  int           bz_busy = 0, bz_stale = 0, bz_ad, bz_sb;
  longint       bz_prod;

  initial begin
    m_done = 1'b1; m_product = '0; m_addcnt = '0; m_subcnt = '0;
  end

  always @(posedge clk) begin
    if (m_start) begin
      booth_counts(m_multiplier, bz_ad, bz_sb);
      bz_prod  = longint'($signed(m_multiplicand)) * longint'($signed(m_multiplier));
      bz_busy  = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 6));
      bz_stale = stale_knob;
      if (bz_stale == 0) m_done <= 1'b0;
    end else if (bz_stale > 0) begin
      bz_stale--;
      if (bz_stale == 0) m_done <= 1'b0;
    end else if (bz_busy > 0) begin
      bz_busy--;
      if (bz_busy == 0) begin
        m_done    <= 1'b1;
        m_product <= bz_prod;
        m_addcnt  <= 5'(bz_ad);
        m_subcnt  <= 5'(bz_sb);
      end
    end
  end

  // ---------------- requester stimulus ----------------
  logic [31:0]     pa [NREQ][CAP];
  logic [31:0]     pb [NREQ][CAP];
  int              ph [NREQ];
  int              pt [NREQ];
  logic [NREQ-1:0] acc_mask;
  bit              rsp_rand = 1'b0;
  bit              rsp_hold = 1'b1;

  task automatic push_op(input int r, input logic [31:0] a, input logic [31:0] b);
    pa[r][pt[r]] = a;
    pb[r][pt[r]] = b;
    pt[r]++;
  endtask

  initial begin : driver
    for (int r = 0; r < NREQ; r++) begin ph[r] = 0; pt[r] = 0; end
    acc_mask = '0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      for (int r = 0; r < NREQ; r++) begin
        if (acc_mask[r]) ph[r]++;
        if (ph[r] < pt[r]) begin
          req_valid[r]        = 1'b1;
          req_a[r*W +: W]     = pa[r][ph[r]];
          req_b[r*W +: W]     = pb[r][ph[r]];
        end else begin
          req_valid[r]        = 1'b0;
        end
      end
      acc_mask  = '0;
      rsp_ready = rsp_rand ? ($urandom_range(0, 2) != 0) : rsp_hold;
    end
  end

  // ---------------- scoreboard and monitor ----------------
  typedef struct {
    int     id;
    longint prod;
    int     ad;
    int     sb;
    int     acc_cyc;
    bit     byp;
  } exp_t;

  exp_t            exp_q[$];
  int              glog[$];
  int              mptr = 0;
  int              n_starts = 0;
  int              last_acc_cyc = -100;
  bit              last_acc_byp = 1'b0;
  bit              prev_rv = 1'b0, prev_rr = 1'b0;
  logic [79:0]     prev_snap;
  longint          prod_by_id [NREQ];
  int              last_id;
  logic [NREQ-1:0] m_hs;
  int              m_g, m_eg, m_j, m_ad, m_sb;
  logic [31:0]     m_a, m_b;
  exp_t            m_e;

  always @(negedge clk) begin
    if (rstn) begin
      chk("ready_onehot0", $onehot0(req_ready), 1);
      if (req_ready != '0) begin
        chk("ready_needs_done", m_done, 1);
        chk("ready_in_resp", rsp_valid, 0);
        chk("ready_needs_valid", (req_ready & ~req_valid) == '0, 1);
      end
      m_hs = req_valid & req_ready;
      if (m_hs != '0) begin
        m_g = 0;
        for (int i = 0; i < NREQ; i++) if (m_hs[i]) m_g = i;
        m_eg = -1;
        for (int k = 0; k < NREQ; k++) begin
          m_j = (mptr + k) % NREQ;
          if (m_eg < 0 && req_valid[m_j]) m_eg = m_j;
        end
        chk("grant_rr", m_g, m_eg);
        mptr = (m_eg + 1) % NREQ;
        glog.push_back(m_g);
        m_a = req_a[m_g*W +: W];
        m_b = req_b[m_g*W +: W];
        booth_counts(m_b, m_ad, m_sb);
        m_e.id      = m_g;
        m_e.prod    = longint'($signed(m_a)) * longint'($signed(m_b));
        m_e.ad      = m_ad;
        m_e.sb      = m_sb;
        m_e.acc_cyc = cyc;
`ifdef BOOTH_ARB_BYPASS_EN
        m_e.byp     = (m_b == 32'd0) || (m_b == 32'hFFFF_FFFF);
`else
        m_e.byp     = 1'b0;
`endif
        exp_q.push_back(m_e);
        acc_mask[m_g] = 1'b1;
        last_acc_cyc  = cyc;
        last_acc_byp  = m_e.byp;
      end
      if (m_start) begin
        n_starts++;
        chk("start_cycle1", cyc - last_acc_cyc, 1);
        chk("start_not_bypass", last_acc_byp, 0);
      end
      if (prev_rv && !prev_rr) begin
        chk("rsp_held", rsp_valid, 1);
        chk("rsp_stable", {rsp_id, rsp_product, rsp_addcnt, rsp_subcnt} == prev_snap[IDW+73:0], 1);
      end
      if (rsp_valid && !prev_rv) begin
        chk("rsp_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          if (exp_q[0].byp) chk("latency_bypass", cyc - exp_q[0].acc_cyc, 1);
          else              chk("latency_min4", (cyc - exp_q[0].acc_cyc) >= 4, 1);
        end
      end
      if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
        m_e = exp_q.pop_front();
        chk("rsp_id", rsp_id, m_e.id);
        chk("rsp_product", rsp_product, m_e.prod);
        chk("rsp_addcnt", rsp_addcnt, m_e.ad);
        chk("rsp_subcnt", rsp_subcnt, m_e.sb);
        prod_by_id[rsp_id] = longint'(rsp_product);
        last_id = int'(rsp_id);
      end
      prev_rv   = rsp_valid;
      prev_rr   = rsp_ready;
      prev_snap = 80'({rsp_id, rsp_product, rsp_addcnt, rsp_subcnt});
    end
  end

  // ---------------- helpers ----------------
  task automatic check_reset_outs(input string p);
    chk({p, "_req_ready"}, req_ready, 0);
    chk({p, "_rsp_valid"}, rsp_valid, 0);
    chk({p, "_rsp_id"}, rsp_id, 0);
    chk({p, "_rsp_product"}, rsp_product, 0);
    chk({p, "_rsp_addcnt"}, rsp_addcnt, 0);
    chk({p, "_rsp_subcnt"}, rsp_subcnt, 0);
    chk({p, "_m_multiplicand"}, m_multiplicand, 0);
    chk({p, "_m_multiplier"}, m_multiplier, 0);
    chk({p, "_m_start"}, m_start, 0);
  endtask

  task automatic assert_reset();
    rstn = 1'b0;
    exp_q.delete();
    glog.delete();
    mptr = 0; prev_rv = 1'b0; prev_rr = 1'b0; acc_mask = '0;
  endtask

  function automatic bit all_idle();
    bit ok;
    ok = (exp_q.size() == 0) && !rsp_valid && (req_valid == '0);
    for (int r = 0; r < NREQ; r++) if (ph[r] != pt[r]) ok = 1'b0;
    return ok;
  endfunction

  task automatic wait_drain(input string nm, input int budget);
    int n;
    bit done;
    n = 0; done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk); n++;
      done = all_idle();
    end
    chk({nm, "_drain"}, done, 1);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed and random tests ----------------
  initial begin : main
    int s0, n, bad;
    logic [79:0] snap;
    rstn = 1'b1;
    #1 assert_reset();
    repeat (3) @(posedge clk);
    #1 check_reset_outs("rst0");
    rstn = 1'b1;

    // single request, 20 * -9
    s0 = n_starts;
    push_op(0, 32'd20, -32'sd9);
    wait_drain("t1", 200);
    chk("t1_starts", n_starts - s0, 1);
    chk("t1_id", last_id, 0);
    chk("t1_prod", prod_by_id[0], -64'sd180);

    // three requesters together from reset, requester 0 twice
    @(posedge clk); #1 assert_reset();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    push_op(0, 32'd100, 32'd1);
    push_op(0, 32'd7, 32'd11);
    push_op(1, 32'd46293, -32'sd3);
    push_op(3, 32'd500, -32'sd5);
    wait_drain("t2", 300);
    chk("t2_ngrants", glog.size(), 4);
    if (glog.size() == 4) begin
      chk("t2_order0", glog[0], 0);
      chk("t2_order1", glog[1], 1);
      chk("t2_order2", glog[2], 3);
      chk("t2_order3", glog[3], 0);
    end
    chk("t2_p1", prod_by_id[1], -64'sd138879);
    chk("t2_p3", prod_by_id[3], -64'sd2500);
    chk("t2_p0", prod_by_id[0], 64'sd77);

    // response back-pressure for 10 cycles
    rsp_hold = 1'b0;
    push_op(2, -32'sd31, 32'd977);
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    chk("t3_rsp_seen", rsp_valid, 1);
    snap = 80'({rsp_id, rsp_product, rsp_addcnt, rsp_subcnt});
    s0 = n_starts;
    push_op(1, 32'd5, 32'd6);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (req_ready != '0) bad++;
      if (m_start) bad++;
      if (!rsp_valid) bad++;
    end
    chk("t3_quiet", bad, 0);
    chk("t3_stable", 80'({rsp_id, rsp_product, rsp_addcnt, rsp_subcnt}) == snap, 1);
    chk("t3_nostart", n_starts - s0, 0);
    rsp_hold = 1'b1;
    wait_drain("t3", 300);

    // reset while booth is busy in WAIT
    lat_fixed = 40;
    push_op(1, 32'd1000, -32'sd1000);
    n = 0;
    while (exp_q.size() == 0 && n < 100) begin @(negedge clk); n++; end
    chk("t4_accepted", exp_q.size(), 1);
    repeat (5) @(posedge clk);
    #1 assert_reset();
    #1 check_reset_outs("rst_wait");
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    lat_fixed = 0;
    push_op(2, -32'sd77, 32'd1234);
    wait_drain("t4", 300);
    chk("t4_id", last_id, 2);
    chk("t4_prod", prod_by_id[2], -64'sd95018);

    // multiplier 0 and -1
    s0 = n_starts;
    push_op(0, 32'd1342, 32'd0);
    push_op(1, -32'sd13476, -32'sd1);
    wait_drain("t5", 300);
`ifdef BOOTH_ARB_BYPASS_EN
    chk("t5_starts", n_starts - s0, 0);
`else
    chk("t5_starts", n_starts - s0, 2);
`endif
    chk("t5_p0", prod_by_id[0], 64'sd0);
    chk("t5_p1", prod_by_id[1], 64'sd13476);

    // stale done held through ARM
    stale_knob = 1;
    push_op(3, 32'd12345, -32'sd678);
    wait_drain("t6", 300);
    stale_knob = 0;
    chk("t6_p3", prod_by_id[3], -64'sd8369910);

    // randomized traffic with random back-pressure and latency
    rsp_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      push_op(int'($urandom_range(0, NREQ - 1)), a, b);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_drain("t7", 4000);
    rsp_rand = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
